response_generator: RTL and testbench
=====================================

RESPONSE_GENERATOR -- requirements
Module: response_generator

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, request address width.
REQ-002 Parameter DATA_WIDTH, default 32, data beat width.
REQ-003 Parameter ID_WIDTH, default 16, AXI transaction ID width.
REQ-004 Parameter TIMEOUT_CYCLES, default 16, memory-ack timeout limit (used only under RESP_TIMEOUT_EN).
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 fifo_empty_i  in  1  request FIFO empty.
REQ-008 fifo_read_en_o  out  1  request FIFO pop strobe.
REQ-009 fifo_data_i  in  ADDR_WIDTH+ID_WIDTH+1  popped entry {rw[MSB] (0=read, 1=write), id, addr[ADDR_WIDTH-1:0]}, valid one cycle after pop.
REQ-010 mem_req_o  out  1  memory access request.
REQ-011 mem_we_o  out  1  memory write enable.
REQ-012 mem_addr_o  out  ADDR_WIDTH  memory address.
REQ-013 mem_wdata_o  out  DATA_WIDTH  memory write data.
REQ-014 mem_ack_i  in  1  memory access complete.
REQ-015 mem_rdata_i  in  DATA_WIDTH  memory read data, valid with mem_ack_i.
REQ-016 wdata_i / wvalid_i / wready_o  in/in/out  DATA_WIDTH/1/1  AXI W channel, single beat.
REQ-017 bid_o / bresp_o / bvalid_o / bready_i  out/out/out/in  ID_WIDTH/2/1/1  AXI B channel.
REQ-018 rid_o / rdata_o / rresp_o / rlast_o / rvalid_o / rready_i  out/out/out/out/out/in  ID_WIDTH/DATA_WIDTH/2/1/1/1  AXI R channel.

Function
REQ-019 The block SHALL implement FSM states S_IDLE, S_POP, S_RMEM, S_WDATA, S_WMEM, S_RRESP, S_BRESP, with one transaction outstanding.
REQ-020 In S_IDLE, fifo_read_en_o SHALL equal !fifo_empty_i; when asserted, next state SHALL be S_POP; otherwise stay.
REQ-021 In S_POP, the block SHALL latch rw, id, addr from fifo_data_i; next state S_RMEM if rw=0, else S_WDATA.
REQ-022 In S_WDATA, wready_o SHALL be 1; on wvalid_i, wdata_i SHALL be latched and next state SHALL be S_WMEM.
REQ-023 In S_RMEM/S_WMEM, mem_req_o SHALL be 1, mem_addr_o SHALL equal latched addr, mem_we_o SHALL be 0/1 respectively, mem_wdata_o SHALL equal latched wdata; held until mem_ack_i.
REQ-024 On mem_ack_i in S_RMEM, mem_rdata_i SHALL be latched, resp set to 2'b00, next state S_RRESP; in S_WMEM, resp set to 2'b00, next state S_BRESP.
REQ-025 In S_RRESP, rvalid_o=1, rlast_o=1, rid_o=latched id, rdata_o/rresp_o stable until rready_i; on rready_i next state S_IDLE.
REQ-026 In S_BRESP, bvalid_o=1, bid_o=latched id, bresp_o stable until bready_i; on bready_i next state S_IDLE.
REQ-027 Valid/ready strobes SHALL be deasserted in every state not listed above; a new pop SHALL not occur before the previous response handshake completes.
REQ-028 Minimum read latency (pop to rvalid_o), with mem_ack_i in first S_RMEM cycle, SHALL be 3 cycles; write (wvalid_i already high) pop to bvalid_o SHALL be 4 cycles.
REQ-029 wvalid_i outside S_WDATA SHALL be ignored (wready_o=0); mem_ack_i outside S_RMEM/S_WMEM SHALL be ignored.

Reset
REQ-030 On rst_n=0 at a clock edge, state SHALL become S_IDLE and all outputs and latched registers SHALL be 0.
REQ-031 Reset mid-transaction SHALL abandon it with no response and no re-pop of the lost entry.

Configuration
REQ-032 Macro RESP_TIMEOUT_EN defined: a counter, cleared on entering S_RMEM/S_WMEM, SHALL increment each cycle without mem_ack_i; when it reaches TIMEOUT_CYCLES-1 without ack, mem_req_o SHALL drop next cycle, resp SHALL be 2'b10 (SLVERR), rdata SHALL be 0, and FSM SHALL go to S_RRESP/S_BRESP.
REQ-033 mem_ack_i in the same cycle as timeout SHALL win (OKAY, real data).
REQ-034 Macro undefined: no counter; memory wait SHALL be unbounded; rresp_o/bresp_o SHALL always be 2'b00.

Verification
REQ-035 Read: entry {0, id=16'h00A5, addr=64'h40}, ack first cycle with rdata 32'hDEADBEEF, rready=1 -> rvalid 3 cycles after pop, rid=16'h00A5, rdata=32'hDEADBEEF, rresp=00, rlast=1.
REQ-036 Write: entry {1, id=16'h0003, addr=64'h80}, wdata 32'h12345678 valid 2 cycles late, ack after 2 cycles -> mem_we=1, mem_addr=64'h80, mem_wdata=32'h12345678; bid=16'h0003, bresp=00.
REQ-037 Backpressure: rready low 5 cycles -> rvalid/rid/rdata held stable; no fifo_read_en_o until rready high.
REQ-038 Back-to-back: FIFO holds read then write -> second pop exactly one cycle after R handshake; responses in FIFO order.
REQ-039 RESP_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> mem_req high 16 cycles, then rvalid with rresp=10, rdata=0; undefined build -> mem_req held indefinitely.
REQ-040 rst_n low during S_WMEM -> next cycle all outputs 0, state S_IDLE; no bvalid issued.

Source files
------------

// File: rtl/response_generator.sv
// Pops one request at a time from the request FIFO, performs the memory access, and answers on the AXI R or B channel.
// Optional build macro RESP_TIMEOUT_EN bounds the memory wait and answers SLVERR when no ack arrives in time.
module response_generator #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int ID_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             fifo_empty_i,
    output logic                             fifo_read_en_o,
    input  logic [ADDR_WIDTH+ID_WIDTH:0]     fifo_data_i,
    output logic                             mem_req_o,
    output logic                             mem_we_o,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    output logic [DATA_WIDTH-1:0]            mem_wdata_o,
    input  logic                             mem_ack_i,
    input  logic [DATA_WIDTH-1:0]            mem_rdata_i,
    input  logic [DATA_WIDTH-1:0]            wdata_i,
    input  logic                             wvalid_i,
    output logic                             wready_o,
    output logic [ID_WIDTH-1:0]              bid_o,
    output logic [1:0]                       bresp_o,
    output logic                             bvalid_o,
    input  logic                             bready_i,
    output logic [ID_WIDTH-1:0]              rid_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic [1:0]                       rresp_o,
    output logic                             rlast_o,
    output logic                             rvalid_o,
    input  logic                             rready_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_RMEM,
        S_WDATA,
        S_WMEM,
        S_RRESP,
        S_BRESP
    } state_t;

    state_t                  state_reg;
    logic                    rw_reg;
    logic [ID_WIDTH-1:0]     id_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic [1:0]              resp_reg;
    logic                    mem_req_reg;
    logic                    wready_reg;
    logic                    rvalid_reg;
    logic                    bvalid_reg;
    logic                    timeout;

`ifdef RESP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_reg;

    // Counts unacknowledged memory-wait cycles; idle value is zero, so entry always starts from zero.
    always_ff @(posedge clk) begin
        if (!rst_n || mem_ack_i || !(state_reg == S_RMEM || state_reg == S_WMEM)) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    assign timeout = (timer_reg == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // The pop strobe must follow fifo_empty_i in the same cycle, so it is decoded rather than registered.
    assign fifo_read_en_o = (state_reg == S_IDLE) && !fifo_empty_i;
    assign mem_req_o      = mem_req_reg;
    assign mem_we_o       = mem_req_reg & rw_reg;
    assign mem_addr_o     = addr_reg;
    assign mem_wdata_o    = wdata_reg;
    assign wready_o       = wready_reg;
    assign bid_o          = id_reg;
    assign bresp_o        = resp_reg;
    assign bvalid_o       = bvalid_reg;
    assign rid_o          = id_reg;
    assign rdata_o        = rdata_reg;
    assign rresp_o        = resp_reg;
    assign rlast_o        = rvalid_reg;
    assign rvalid_o       = rvalid_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            rw_reg      <= 1'b0;
            id_reg      <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            resp_reg    <= 2'b00;
            mem_req_reg <= 1'b0;
            wready_reg  <= 1'b0;
            rvalid_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (!fifo_empty_i) begin
                        state_reg <= S_POP;
                    end
                end
                S_POP: begin
                    {rw_reg, id_reg, addr_reg} <= fifo_data_i;
                    if (fifo_data_i[ADDR_WIDTH+ID_WIDTH]) begin
                        wready_reg <= 1'b1;
                        state_reg  <= S_WDATA;
                    end else begin
                        mem_req_reg <= 1'b1;
                        state_reg   <= S_RMEM;
                    end
                end
                S_WDATA: begin
                    if (wvalid_i) begin
                        wdata_reg   <= wdata_i;
                        wready_reg  <= 1'b0;
                        mem_req_reg <= 1'b1;
                        state_reg   <= S_WMEM;
                    end
                end
                S_RMEM, S_WMEM: begin
                    // An ack arriving together with the timeout wins and returns real data.
                    if (mem_ack_i || timeout) begin
                        mem_req_reg <= 1'b0;
                        resp_reg    <= mem_ack_i ? 2'b00 : 2'b10;
                        if (state_reg == S_RMEM) begin
                            rdata_reg  <= mem_ack_i ? mem_rdata_i : '0;
                            rvalid_reg <= 1'b1;
                            state_reg  <= S_RRESP;
                        end else begin
                            bvalid_reg <= 1'b1;
                            state_reg  <= S_BRESP;
                        end
                    end
                end
                S_RRESP: begin
                    if (rready_i) begin
                        rvalid_reg <= 1'b0;
                        state_reg  <= S_IDLE;
                    end
                end
                S_BRESP: begin
                    if (bready_i) begin
                        bvalid_reg <= 1'b0;
                        state_reg  <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_response_generator.sv
// Scoreboard bench for response_generator: FIFO, memory and W-channel models plus expected-response queue.
// Build with RESP_TIMEOUT_EN defined to exercise the timeout variant.
module tb_response_generator;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int IW = 16;

    typedef struct {
        logic          rw;
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
        int            lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             fifo_empty_i;
    logic             fifo_read_en_o;
    logic [AW+IW:0]   fifo_data_i;
    logic             mem_req_o;
    logic             mem_we_o;
    logic [AW-1:0]    mem_addr_o;
    logic [DW-1:0]    mem_wdata_o;
    logic             mem_ack_i;
    logic [DW-1:0]    mem_rdata_i;
    logic [DW-1:0]    wdata_i;
    logic             wvalid_i;
    logic             wready_o;
    logic [IW-1:0]    bid_o;
    logic [1:0]       bresp_o;
    logic             bvalid_o;
    logic             bready_i;
    logic [IW-1:0]    rid_o;
    logic [DW-1:0]    rdata_o;
    logic [1:0]       rresp_o;
    logic             rlast_o;
    logic             rvalid_o;
    logic             rready_i;

    response_generator #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_empty_i(fifo_empty_i), .fifo_read_en_o(fifo_read_en_o), .fifo_data_i(fifo_data_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
        .rvalid_o(rvalid_o), .rready_i(rready_i)
    );

    always #5 clk = ~clk;

    exp_t           exp_q[$];
    logic [AW+IW:0] fifo_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pop_cyc = 0;
    int hs_cyc = 0;
    int pop_gap = -1;
    int req_cycles = 0;
    int mem_wait = 0;
    int w_wait = 0;
    int mem_delay = 0;
    int w_delay = 0;
    bit mem_stall = 0;
    bit ack_spam = 0;
    bit w_spam = 0;
    bit prev_rvalid = 0;
    bit prev_bvalid = 0;

    task automatic push_txn(input logic rw, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [1:0] resp, input int lat);
        exp_t e;
        e.rw = rw; e.id = id; e.addr = addr; e.resp = resp; e.lat = lat;
        e.wdata = rw ? data : '0;
        e.rdata = rw ? '0 : data;
        exp_q.push_back(e);
        fifo_q.push_back({rw, id, addr});
        fifo_empty_i = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, then update the input models after the rising edge.
    task automatic step();
        bit pop_now;
        @(negedge clk);
        cyc++;
        if (mem_req_o) req_cycles++;
        if (mem_req_o && mem_ack_i && exp_q.size() > 0) begin
            n_checks++;
            if (mem_we_o !== exp_q[0].rw || mem_addr_o !== exp_q[0].addr ||
                (exp_q[0].rw && mem_wdata_o !== exp_q[0].wdata)) begin
                n_errors++;
                $display("FAIL mem_access: got we=%0b addr=%h wdata=%h, expected we=%0b addr=%h wdata=%h",
                         mem_we_o, mem_addr_o, mem_wdata_o, exp_q[0].rw, exp_q[0].addr, exp_q[0].wdata);
            end
        end
        if (rvalid_o === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_rvalid: got rvalid=1 rid=%h, expected no response", rid_o);
            end else begin
                if (!prev_rvalid && exp_q[0].lat >= 0) begin
                    n_checks++;
                    if (cyc - pop_cyc !== exp_q[0].lat) begin
                        n_errors++;
                        $display("FAIL read_latency: got %0d, expected %0d", cyc - pop_cyc, exp_q[0].lat);
                    end
                end
                if (exp_q[0].rw !== 1'b0 || rid_o !== exp_q[0].id || rdata_o !== exp_q[0].rdata ||
                    rresp_o !== exp_q[0].resp || rlast_o !== 1'b1) begin
                    n_errors++;
                    $display("FAIL r_beat: got rid=%h rdata=%h rresp=%b rlast=%b, expected rw=%0b rid=%h rdata=%h rresp=%b rlast=1",
                             rid_o, rdata_o, rresp_o, rlast_o, exp_q[0].rw, exp_q[0].id, exp_q[0].rdata, exp_q[0].resp);
                end
                if (rready_i) begin
                    $display("R  id=%h data=%h resp=%b at cycle %0d", rid_o, rdata_o, rresp_o, cyc);
                    void'(exp_q.pop_front());
                    hs_cyc = cyc;
                end
            end
        end
        if (bvalid_o === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_bvalid: got bvalid=1 bid=%h, expected no response", bid_o);
            end else begin
                if (!prev_bvalid && exp_q[0].lat >= 0) begin
                    n_checks++;
                    if (cyc - pop_cyc !== exp_q[0].lat) begin
                        n_errors++;
                        $display("FAIL write_latency: got %0d, expected %0d", cyc - pop_cyc, exp_q[0].lat);
                    end
                end
                if (exp_q[0].rw !== 1'b1 || bid_o !== exp_q[0].id || bresp_o !== exp_q[0].resp) begin
                    n_errors++;
                    $display("FAIL b_beat: got bid=%h bresp=%b, expected rw=%0b bid=%h bresp=%b",
                             bid_o, bresp_o, exp_q[0].rw, exp_q[0].id, exp_q[0].resp);
                end
                if (bready_i) begin
                    $display("B  id=%h resp=%b at cycle %0d", bid_o, bresp_o, cyc);
                    void'(exp_q.pop_front());
                    hs_cyc = cyc;
                end
            end
        end
        prev_rvalid = (rvalid_o === 1'b1);
        prev_bvalid = (bvalid_o === 1'b1);
        pop_now = (fifo_read_en_o === 1'b1);
        if (pop_now) begin
            n_checks++;
            if (rvalid_o !== 1'b0 || bvalid_o !== 1'b0 || mem_req_o !== 1'b0 || fifo_q.size() == 0) begin
                n_errors++;
                $display("FAIL pop_overlap: got pop with rvalid=%b bvalid=%b mem_req=%b fifo=%0d, expected idle and non-empty",
                         rvalid_o, bvalid_o, mem_req_o, fifo_q.size());
            end
            pop_cyc = cyc;
            pop_gap = cyc - hs_cyc;
        end
        @(posedge clk);
        #1;
        if (pop_now && fifo_q.size() > 0) fifo_data_i = fifo_q.pop_front();
        fifo_empty_i = (fifo_q.size() == 0);
        mem_wait  = mem_req_o ? mem_wait + 1 : 0;
        mem_ack_i = mem_req_o ? (!mem_stall && mem_wait > mem_delay) : ack_spam;
        mem_rdata_i = (mem_req_o && mem_ack_i && exp_q.size() > 0) ? exp_q[0].rdata : 32'h5A5A_5A5A;
        w_wait   = wready_o ? w_wait + 1 : 0;
        wvalid_i = wready_o ? (w_wait > w_delay) : w_spam;
        wdata_i  = (wready_o && wvalid_i && exp_q.size() > 0) ? exp_q[0].wdata : 32'hBAD0_BAD0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic run_until_done(input int budget, input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got %0d responses outstanding after %0d cycles, expected 0", name, exp_q.size(), budget);
            exp_q.delete();
            fifo_q.delete();
            fifo_empty_i = 1'b1;
            apply_reset();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({fifo_read_en_o, mem_req_o, mem_we_o, wready_o, bvalid_o, rvalid_o, rlast_o} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_strobes: got %b, expected 0000000",
                     {fifo_read_en_o, mem_req_o, mem_we_o, wready_o, bvalid_o, rvalid_o, rlast_o});
        end
        n_checks++;
        if (mem_addr_o !== '0 || mem_wdata_o !== '0 || bid_o !== '0 || rid_o !== '0 ||
            rdata_o !== '0 || rresp_o !== '0 || bresp_o !== '0) begin
            n_errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h bid=%h rid=%h rdata=%h, expected all 0",
                     mem_addr_o, mem_wdata_o, bid_o, rid_o, rdata_o);
        end
    endtask

    task automatic test_read();
        mem_delay = 0; rready_i = 1'b1;
        push_txn(1'b0, 16'h00A5, 64'h40, 32'hDEAD_BEEF, 2'b00, 3);
        run_until_done(30, "read");
    endtask

    task automatic test_write();
        mem_delay = 2; w_delay = 2; bready_i = 1'b1;
        push_txn(1'b1, 16'h0003, 64'h80, 32'h1234_5678, 2'b00, 8);
        run_until_done(30, "write");
        w_delay = 0; mem_delay = 0;
    endtask

    task automatic test_backpressure();
        int n = 0;
        rready_i = 1'b0;
        push_txn(1'b0, 16'h0011, 64'h1000, 32'hA5A5_0001, 2'b00, 3);
        push_txn(1'b0, 16'h0012, 64'h1008, 32'hA5A5_0002, 2'b00, 3);
        while (rvalid_o !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        repeat (5) step();
        n_checks++;
        if (exp_q.size() !== 2 || fifo_q.size() !== 1) begin
            n_errors++;
            $display("FAIL backpressure_hold: got outstanding=%0d fifo=%0d, expected 2 and 1", exp_q.size(), fifo_q.size());
        end
        rready_i = 1'b1;
        run_until_done(40, "backpressure");
    endtask

    task automatic test_back_to_back();
        ack_spam = 1'b1; w_spam = 1'b1;
        push_txn(1'b0, 16'h0021, 64'h2000, 32'h0BAD_F00D, 2'b00, 3);
        push_txn(1'b1, 16'h0022, 64'h2040, 32'hFEED_0022, 2'b00, 4);
        run_until_done(40, "back_to_back");
        n_checks++;
        if (pop_gap !== 1) begin
            n_errors++;
            $display("FAIL b2b_pop_gap: got %0d cycles after R handshake, expected 1", pop_gap);
        end
        ack_spam = 1'b0; w_spam = 1'b0;
    endtask

    task automatic test_mixed();
        mem_delay = 1; w_delay = 1;
        for (int i = 0; i < 6; i++) begin
            logic          rw;
            logic [IW-1:0] id;
            rw = 1'($urandom_range(0, 1));
            id = IW'($urandom);
            push_txn(rw, id, 64'h3000 + 64'(i * 8), $urandom, 2'b00, rw ? 6 : 4);
        end
        run_until_done(120, "mixed");
        mem_delay = 0; w_delay = 0;
    endtask

    task automatic test_timeout();
        int n = 0;
        mem_stall = 1'b1;
        req_cycles = 0;
`ifdef RESP_TIMEOUT_EN
        push_txn(1'b0, 16'h0007, 64'h100, 32'h0, 2'b10, 18);
        run_until_done(60, "timeout");
        n_checks++;
        if (req_cycles !== 16) begin
            n_errors++;
            $display("FAIL timeout_req_cycles: got %0d, expected 16", req_cycles);
        end
        mem_stall = 1'b0;
`else
        push_txn(1'b0, 16'h0007, 64'h100, 32'hCAFE_F00D, 2'b00, -1);
        while (mem_req_o !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        req_cycles = 0;
        repeat (40) step();
        n_checks++;
        if (req_cycles !== 40 || exp_q.size() !== 1) begin
            n_errors++;
            $display("FAIL unbounded_wait: got req_cycles=%0d outstanding=%0d, expected 40 and 1", req_cycles, exp_q.size());
        end
        mem_stall = 1'b0;
        run_until_done(20, "unbounded");
`endif
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit bseen = 0;
        mem_stall = 1'b1;
        push_txn(1'b1, 16'h0003, 64'h80, 32'h1234_5678, 2'b00, -1);
        while (!(mem_req_o === 1'b1 && mem_we_o === 1'b1) && n < 20) begin
            step();
            n++;
        end
        rst_n = 1'b0;
        void'(exp_q.pop_front());
        step();
        n_checks++;
        if ({mem_req_o, mem_we_o, wready_o, bvalid_o, rvalid_o} !== 5'b0 || mem_addr_o !== '0 ||
            mem_wdata_o !== '0 || bid_o !== '0) begin
            n_errors++;
            $display("FAIL reset_mid: got req=%b we=%b bvalid=%b addr=%h wdata=%h bid=%h, expected all 0",
                     mem_req_o, mem_we_o, bvalid_o, mem_addr_o, mem_wdata_o, bid_o);
        end
        rst_n = 1'b1;
        mem_stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bvalid_o === 1'b1 || fifo_read_en_o === 1'b1) bseen = 1;
        end
        n_checks++;
        if (bseen !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_abandon: got bvalid or pop after reset, expected none");
        end
        push_txn(1'b0, 16'h0055, 64'h500, 32'h5555_AAAA, 2'b00, 3);
        run_until_done(30, "after_reset");
    endtask

    initial begin
        rst_n = 1'b0; fifo_empty_i = 1'b1; fifo_data_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0; wdata_i = '0; wvalid_i = 1'b0;
        bready_i = 1'b1; rready_i = 1'b1;
        test_reset();
        test_read();
        test_write();
        test_backpressure();
        test_back_to_back();
        test_mixed();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
